bias_accum_ctrl: RTL and testbench



---
 rtl/bias_accum_ctrl_pkg.sv | 34 +++
 rtl/bias_accum_ctrl_lane.sv | 69 ++++++
 rtl/bias_accum_ctrl.sv | 169 ++++++++++++++++
 tb/tb_bias_accum_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_accum_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bias_accum_ctrl_pkg
// Shared definitions for the convolution output stage:
//   LANE_W   - signed lane width (two's complement)
//   state_e  - sequencer FSM states
//   sat_add  - W+1-bit add of two LANE_W signed values, clamped back to LANE_W
// -----------------------------------------------------------------------------
package bias_accum_ctrl_pkg;

    localparam int LANE_W = 18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_BIAS  = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    function automatic logic signed [LANE_W-1:0] sat_add(
        input logic signed [LANE_W-1:0] a,
        input logic signed [LANE_W-1:0] b
    );
        logic signed [LANE_W:0] sum;
        sum = {a[LANE_W-1], a} + {b[LANE_W-1], b};
        // The two top bits disagree only when the true sum left the W-bit range.
        if (sum[LANE_W] != sum[LANE_W-1]) begin
            sat_add = sum[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}}
                                  : {1'b0, {(LANE_W-1){1'b1}}};
        end else begin
            sat_add = sum[LANE_W-1:0];
        end
    endfunction

endpackage

// File: rtl/bias_accum_ctrl_lane.sv
// -----------------------------------------------------------------------------
// bias_lane_acc
// One W-bit signed saturating accumulator lane.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (acc cleared)
//   clr         - synchronous clear of the accumulator (wins over add_en)
//   add_en      - acc <= sat(acc + operand)
//   operand     - W-bit signed addend
//   acc         - registered accumulator value
// -----------------------------------------------------------------------------
module bias_lane_acc
    import bias_accum_ctrl_pkg::*;
#(
    parameter int W = LANE_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                add_en,
    input  logic signed [W-1:0] operand,
    output logic signed [W-1:0] acc
);

    // Width-generic saturating add, used only when W differs from the layer width.
    function automatic logic signed [W-1:0] sat_add_w(
        input logic signed [W-1:0] a,
        input logic signed [W-1:0] b
    );
        logic signed [W:0] sum;
        sum = {a[W-1], a} + {b[W-1], b};
        if (sum[W] != sum[W-1]) begin
            sat_add_w = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            sat_add_w = sum[W-1:0];
        end
    endfunction

    logic signed [W-1:0] acc_q;
    logic signed [W-1:0] acc_d;
    logic signed [W-1:0] sum;

    generate
        if (W == LANE_W) begin : g_pkg_sat
            assign sum = sat_add(acc_q, operand);
        end else begin : g_local_sat
            assign sum = sat_add_w(acc_q, operand);
        end
    endgenerate

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (add_en) begin
            acc_d = sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/bias_accum_ctrl.sv
// -----------------------------------------------------------------------------
// bias_accum_ctrl
// Output-stage sequencer for one convolution layer. Per output group it
// accumulates N_CHUNKS partial-sum beats (saturating after every add), adds the
// group's bias vector for one cycle, then offers the result downstream. Runs
// N_GROUPS groups per start.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start               - run request, honoured only in IDLE
//   in_valid/in_ready   - partial-sum beat handshake (in_ready registered)
//   in_data             - N_adder_tree packed W-bit lanes
//   bias_sel            - current group, selects the bias bank
//   bias_q              - bias vector of the selected bank
//   out_valid/out_ready - result handshake (out_valid registered)
//   out_data            - biased, saturated result lanes
//   busy                - not IDLE
//   done                - one-cycle pulse after the last group is accepted
// -----------------------------------------------------------------------------
module bias_accum_ctrl
    import bias_accum_ctrl_pkg::*;
#(
    parameter int N_adder_tree = 16,
    parameter int W            = LANE_W,
    parameter int N_CHUNKS     = 9,
    parameter int N_GROUPS     = 4,
    localparam int SEL_W       = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1,
    localparam int CHUNK_W     = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_adder_tree*W-1:0] in_data,
    output logic [SEL_W-1:0]          bias_sel,
    input  logic [N_adder_tree*W-1:0] bias_q,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_adder_tree*W-1:0] out_data,
    output logic                      busy,
    output logic                      done
);

    localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(N_CHUNKS - 1);
    localparam logic [SEL_W-1:0]   LAST_GROUP = SEL_W'(N_GROUPS - 1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   group_q, group_d;
    logic [CHUNK_W-1:0] chunk_q, chunk_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               lane_clr;
    logic               lane_add;
    logic               op_is_bias;

    always_comb begin
        state_d    = state_q;
        group_d    = group_q;
        chunk_d    = chunk_q;
        done_d     = 1'b0;
        lane_clr   = 1'b0;
        lane_add   = 1'b0;
        op_is_bias = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    group_d  = '0;
                    chunk_d  = '0;
                    lane_clr = 1'b1;
                    state_d  = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (in_valid && in_ready_q) begin
                    lane_add = 1'b1;
                    if (chunk_q == LAST_CHUNK) begin
                        chunk_d = '0;
                        state_d = ST_BIAS;
                    end else begin
                        chunk_d = chunk_q + CHUNK_W'(1);
                    end
                end
            end
            ST_BIAS: begin
                lane_add   = 1'b1;
                op_is_bias = 1'b1;
                state_d    = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (group_q == LAST_GROUP) begin
                        // Return bias_sel to 0 so it reads 0 while idle.
                        group_d = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        group_d  = group_q + SEL_W'(1);
                        lane_clr = 1'b1;
                        state_d  = ST_ACCUM;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake/status outputs are decoded from the next state so they are
        // registered and line up with the state they describe.
        in_ready_d  = (state_d == ST_ACCUM);
        out_valid_d = (state_d == ST_OUT);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            group_q     <= '0;
            chunk_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            group_q     <= group_d;
            chunk_q     <= chunk_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Lane accumulators; operand is the beat in ACCUM and the bias in BIAS.
    // The accumulator holds during OUT, which keeps out_data stable.
    generate
        for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
            logic signed [W-1:0] operand;
            logic signed [W-1:0] acc;

            assign operand = op_is_bias ? bias_q[i*W +: W] : in_data[i*W +: W];

            bias_lane_acc #(
                .W(W)
            ) u_lane (
                .clk    (clk),
                .rst_n  (rst_n),
                .clr    (lane_clr),
                .add_en (lane_add),
                .operand(operand),
                .acc    (acc)
            );

            assign out_data[i*W +: W] = acc;
        end
    endgenerate

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign bias_sel  = group_q;

endmodule

// File: tb/tb_bias_accum_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bias_accum_ctrl
// Randomized scoreboard bench for bias_accum_ctrl (N_CHUNKS=3, N_GROUPS=2).
// The driver feeds beats and pushes the expected group result into a queue
// once a group's beats are all accepted; a monitor pops and compares on every
// output handshake.
// -----------------------------------------------------------------------------
module tb_bias_accum_ctrl;

    localparam int NL = 16;
    localparam int W  = 18;
    localparam int NC = 3;
    localparam int NG = 2;
    localparam int VW = NL * W;
    localparam int SAT_MAX = (1 << (W - 1)) - 1;
    localparam int SAT_MIN = -(1 << (W - 1));

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [VW-1:0] in_data = '0;
    logic [0:0]    bias_sel;
    logic [VW-1:0] bias_q;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [VW-1:0] out_data;
    logic          busy;
    logic          done;

    logic [VW-1:0] bias_mem [NG];
    assign bias_q = bias_mem[bias_sel];

    bias_accum_ctrl #(
        .N_adder_tree(NL),
        .W           (W),
        .N_CHUNKS    (NC),
        .N_GROUPS    (NG)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .bias_sel (bias_sel),
        .bias_q   (bias_q),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_i(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_v(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int            macc [NL];
    int            mchunk;
    int            mgroup;
    logic [VW-1:0] exp_q [$];

    function automatic int clampw(input int v);
        if (v > SAT_MAX) return SAT_MAX;
        if (v < SAT_MIN) return SAT_MIN;
        return v;
    endfunction

    function automatic int slane(input logic [VW-1:0] v, input int i);
        logic signed [W-1:0] s;
        s = v[i*W +: W];
        return int'(s);
    endfunction

    function automatic int ulane(input logic [VW-1:0] v, input int i);
        logic [W-1:0] u;
        u = v[i*W +: W];
        return int'(u);
    endfunction

    task automatic model_clear();
        for (int l = 0; l < NL; l++) macc[l] = 0;
        mchunk = 0;
    endtask

    task automatic model_accept(input logic [VW-1:0] d);
        logic [VW-1:0] r;
        for (int l = 0; l < NL; l++) macc[l] = clampw(macc[l] + slane(d, l));
        mchunk++;
        if (mchunk == NC) begin
            r = '0;
            for (int l = 0; l < NL; l++)
                r[l*W +: W] = W'(clampw(macc[l] + slane(bias_mem[mgroup], l)));
            exp_q.push_back(r);
            mgroup = (mgroup + 1) % NG;
            model_clear();
        end
    endtask

    // ---------------- monitor ----------------
    int            mon_grp = 0;
    logic [VW-1:0] last_out = '0;
    logic [VW-1:0] hold_out = '0;
    bit            hold_vld = 1'b0;
    bit            sel_chk  = 1'b0;
    int            done_cnt = 0;
    int            done_cyc = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (sel_chk) begin
                    check_i("bias_sel_after_handshake", int'(bias_sel), mon_grp);
                    sel_chk = 1'b0;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    check_i("busy_low_with_done", int'(busy), 0);
                end
                if (out_valid) begin
                    check_i("in_ready_low_in_out", int'(in_ready), 0);
                    if (hold_vld) check_v("out_data_stable", out_data, hold_out);
                    if (out_ready) begin
                        check_i("bias_sel_at_handshake", int'(bias_sel), mon_grp);
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_output: got %h expected none", out_data);
                        end else begin
                            check_v("out_data", out_data, exp_q.pop_front());
                        end
                        last_out = out_data;
                        mon_grp  = (mon_grp + 1) % NG;
                        sel_chk  = 1'b1;
                        hold_vld = 1'b0;
                    end else begin
                        hold_out = out_data;
                        hold_vld = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    // mode 0: all lanes 5; 1: random; 2: random extremes; 3: directed saturation
    function automatic logic [VW-1:0] gen_beat(input int mode, input int beat);
        logic [VW-1:0] d;
        logic [W-1:0]  pick [5];
        pick[0] = 18'h1FFFF; pick[1] = 18'h20000; pick[2] = 18'h00001;
        pick[3] = 18'h3FFFF; pick[4] = W'($urandom);
        d = '0;
        for (int l = 0; l < NL; l++) begin
            case (mode)
                0: d[l*W +: W] = 18'd5;
                1: d[l*W +: W] = W'($urandom);
                2: d[l*W +: W] = pick[$urandom_range(0, 4)];
                default: d[l*W +: W] = '0;
            endcase
        end
        if (mode == 3) begin
            case (beat)
                0: begin d[0*W +: W] = 18'h1FFFF; d[3*W +: W] = 18'h20000; end
                1: begin d[0*W +: W] = 18'h00001; d[3*W +: W] = 18'h3FFFF; end
                default: ;
            endcase
        end
        return d;
    endfunction

    task automatic random_bias();
        for (int g = 0; g < NG; g++)
            for (int l = 0; l < NL; l++) bias_mem[g][l*W +: W] = W'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_i({tag, "_in_ready"}, int'(in_ready), 0);
        check_i({tag, "_out_valid"}, int'(out_valid), 0);
        check_i({tag, "_busy"}, int'(busy), 0);
        check_i({tag, "_done"}, int'(done), 0);
        check_i({tag, "_bias_sel"}, int'(bias_sel), 0);
        check_v({tag, "_out_data"}, out_data, '0);
    endtask

    task automatic run_job(input int mode, input int vpct, input int rpct,
                           input bit hold7, input bit ghost, input bit do_rst,
                           output int start_cyc);
        int            d0;
        int            hold;
        bit            was_reset;
        logic [VW-1:0] d;
        bit            v;
        d0 = done_cnt;
        hold = 0;
        was_reset = 1'b0;
        mgroup = 0;
        model_clear();
        @(posedge clk); #1;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        check_i("in_ready_after_start", int'(in_ready), 1);
        check_i("busy_after_start", int'(busy), 1);
        for (int k = 0; k < 2000 && done_cnt == d0; k++) begin
            start = ghost && busy && ($urandom_range(0, 7) == 0);
            v = ($urandom_range(0, 99) < vpct);
            d = gen_beat(mode, mchunk);
            in_valid = v;
            in_data  = d;
            if (v && in_ready) model_accept(d);
            if (hold7 && out_valid && hold < 7) begin
                out_ready = 1'b0;
                hold++;
            end else begin
                out_ready = ($urandom_range(0, 99) < rpct);
            end
            if (do_rst && mgroup == 1 && mchunk == 1) begin
                #2 rst_n = 1'b0;
                #1 check_reset_outputs("mid_reset");
                exp_q.delete();
                mon_grp  = 0;
                hold_vld = 1'b0;
                sel_chk  = 1'b0;
                was_reset = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        if (was_reset) begin
            repeat (3) @(negedge clk);
            check_i("no_done_after_reset", done_cnt - d0, 0);
            rst_n = 1'b1;
        end else begin
            check_i("job_done_once", done_cnt - d0, 1);
            check_i("all_results_seen", exp_q.size(), 0);
            repeat (4) @(posedge clk);
            #1 check_i("no_extra_done", done_cnt - d0, 1);
            check_i("idle_after_job", int'(busy), 0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int sc;
        for (int g = 0; g < NG; g++) bias_mem[g] = '0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check_reset_outputs("post_reset_idle");

        // Basic run: 3 x 5 + 0x100 = 0x10F per lane, done 11 cycles after start.
        for (int g = 0; g < NG; g++)
            for (int l = 0; l < NL; l++) bias_mem[g][l*W +: W] = 18'h00100;
        run_job(0, 100, 100, 1'b0, 1'b0, 1'b0, sc);
        check_i("done_latency", done_cyc - sc, 2 * (NC + 2) + 1);
        check_i("basic_lane0", ulane(last_out, 0), 'h0010F);
        check_i("basic_lane15", ulane(last_out, 15), 'h0010F);

        // Positive / negative saturation with opposite-sign bias afterwards.
        for (int g = 0; g < NG; g++) begin
            bias_mem[g] = '0;
            bias_mem[g][0*W +: W] = 18'h3FF00;
            bias_mem[g][3*W +: W] = 18'h00010;
        end
        run_job(3, 100, 100, 1'b0, 1'b0, 1'b0, sc);
        check_i("sat_pos_lane0", ulane(last_out, 0), 'h1FEFF);
        check_i("sat_neg_lane3", ulane(last_out, 3), 'h20010);

        // Backpressure: out_ready held low for 7 cycles in the first OUT.
        random_bias();
        run_job(1, 100, 100, 1'b1, 1'b0, 1'b0, sc);

        // Gaps, random backpressure, ignored start pulses.
        for (int j = 0; j < 3; j++) begin
            random_bias();
            run_job(2, 50, 60, 1'b0, 1'b1, 1'b0, sc);
            random_bias();
            run_job(1, 70, 40, 1'b0, 1'b1, 1'b0, sc);
        end

        // Reset during ACCUM of group 1, then a clean run from group 0.
        random_bias();
        run_job(1, 80, 100, 1'b0, 1'b0, 1'b1, sc);
        @(posedge clk);
        #1 check_reset_outputs("after_reset_release");
        random_bias();
        run_job(1, 90, 70, 1'b0, 1'b0, 1'b0, sc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got simulation time %0t expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule
